pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives enable/flush of PC, IFID, IDEX, EXMEM, MEMWB.
//  Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
//  Watchdog flags a hung memory; 32-bit stall/flush counters support performance debug.
// PARAMETERS
//  RS_W      5    register address width (rs1/rs2/rd)
//  TIMEOUT   64   max consecutive dmem wait cycles before error (>=2)
//  CNT_W     32   width of performance counters
// PORTS
//  clk            in   1      system clock, rising edge
//  rst_n          in   1      asynchronous active-low reset
//  rs1_id         in   RS_W   rs1 of instruction in ID
//  rs2_id         in   RS_W   rs2 of instruction in ID
//  rs1_used_id    in   1      ID instruction reads rs1
//  rs2_used_id    in   1      ID instruction reads rs2
//  rd_ex          in   RS_W   rd of instruction in EX
//  memread_ex     in   1      EX instruction is a load
//  branch_taken_ex in  1      EX resolved a taken branch/jump
//  dmem_req_mem   in   1      MEM stage is accessing data memory
//  dmem_ready     in   1      data memory completes access this cycle
//  pc_en          out  1      PC update enable
//  ifid_en        out  1      IFID load enable
//  ifid_flush     out  1      IFID load bubble (priority over ifid_en)
//  idex_en        out  1      IDEX load enable
//  idex_flush     out  1      IDEX load bubble
//  exmem_en       out  1      EXMEM load enable
//  memwb_bubble   out  1      MEMWB loads with regwrite/memtoreg forced 0
//  mem_timeout    out  1      sticky error: dmem wait exceeded TIMEOUT
//  stall_cnt      out  CNT_W  cycles with pc_en=0 (saturating)
//  flush_cnt      out  CNT_W  branch flush events (saturating)
// BEHAVIOUR
//  FSM (registered): RUN, WAIT, ERR. Reset -> RUN, wait_cnt=0, mem_timeout=0, counters=0.
//  While rst_n=0: all enables/flush/bubble outputs 0 (pipeline frozen).
//  Combinational conditions:
//   mw = dmem_req_mem & ~dmem_ready
//   lu = memread_ex & rd_ex!=0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex))
//   br = branch_taken_ex
//  Priority ERR > mw > br > lu > normal:
//   ERR : all enables 0, flushes 0, memwb_bubble=1; held until reset.
//   mw  : pc/ifid/idex/exmem en=0, flushes 0, memwb_bubble=1. br/lu ignored this cycle (re-evaluated later).
//   br  : all en=1, ifid_flush=1, idex_flush=1, memwb_bubble=0. lu ignored (ID instr is discarded).
//   lu  : pc_en=0, ifid_en=0, idex_flush=1 (idex_en=1), exmem_en=1, memwb_bubble=0. Exactly 1 bubble per hazard.
//   normal: all en=1, flushes 0, memwb_bubble=0.
//  Transitions: RUN->WAIT when mw (wait_cnt<=1). WAIT: mw -> wait_cnt+1; ~mw -> RUN, wait_cnt=0.
//   WAIT with mw and wait_cnt==TIMEOUT-1 -> ERR, mem_timeout<=1 next edge (TIMEOUT stall cycles total).
//   dmem_ready on the same cycle as timeout check wins (no error).
//  Outputs combinational from state + inputs; zero-latency, no input registering.
//  stall_cnt +1 each cycle pc_en=0 outside reset (incl. ERR); flush_cnt +1 each cycle br wins; both saturate at all-ones.
//  rd_ex==0 never causes load-use stall. Async reset mid-WAIT/ERR returns to RUN immediately.
// TESTING
//  Load x5 in EX, ID reads rs1=5 used -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal; stall_cnt=1.
//  Load rd_ex=0, rs1_id=0 used -> no stall; rs2 match with rs2_used_id=0 -> no stall.
//  branch_taken_ex=1 together with load-use -> ifid_flush=idex_flush=1, pc_en=1, flush_cnt=1, stall_cnt=0.
//  dmem_req=1, ready low 3 cycles then high -> 3 cycles frozen+memwb_bubble, back to RUN, stall_cnt=3.
//  TIMEOUT=4, ready never rises -> mem_timeout=1 after 4 stall cycles, outputs frozen; rst_n=0 clears all.
//  Counter saturation (CNT_W=4): 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Resolves dmem waits, taken branches and load-use hazards; watchdog plus perf counters.
module pipe_hazard_ctrl #(
  parameter int RS_W    = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RS_W-1:0]  rs1_id,
  input  logic [RS_W-1:0]  rs2_id,
  input  logic             rs1_used_id,
  input  logic             rs2_used_id,
  input  logic [RS_W-1:0]  rd_ex,
  input  logic             memread_ex,
  input  logic             branch_taken_ex,
  input  logic             dmem_req_mem,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [WC_W-1:0]  wait_cnt, wait_cnt_d;
  logic             timeout_d;
  logic             mw, lu, br, flush_ev;

  assign mw = dmem_req_mem & ~dmem_ready;
  assign br = branch_taken_ex;
  assign lu = memread_ex & (rd_ex != '0) &
              ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));

  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    timeout_d  = mem_timeout;
    case (state)
      RUN: begin
        if (mw) begin
          state_d    = WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      WAIT: begin
        if (!mw) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          // wait_cnt already counts the cycle that entered WAIT, so this is stall cycle TIMEOUT
          state_d   = ERR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt + WC_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    idex_en      = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b0;
    memwb_bubble = 1'b0;
    flush_ev     = 1'b0;
    if (!rst_n) begin
      memwb_bubble = 1'b0;
    end else if (state == ERR || mw) begin
      memwb_bubble = 1'b1;
    end else if (br) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      flush_ev   = 1'b1;
    end else if (lu) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_d;
      wait_cnt    <= wait_cnt_d;
      mem_timeout <= timeout_d;
      if (!pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
